// File: rtl/chip8_pkg.sv
// Shared types for the Chip8 subroutine-return stack: operation codes and
// the controller state encoding that is exported for debug.
package chip8_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_PEEK = 2'b11
    } stack_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RD_WAIT = 2'b01,
        ST_DONE    = 2'b10
    } stack_state_e;

    // Pop and peek both fetch the top entry; only pop moves the pointer.
    function automatic logic is_read_op(stack_op_e op);
        return (op == OP_POP) || (op == OP_PEEK);
    endfunction

endpackage

// File: rtl/chip8_call_stack_if.sv
// CPU-side request/response bundle for chip8_call_stack, including the
// status flags and the controller state for debug visibility.
interface chip8_call_stack_if
    import chip8_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
);
    localparam int PTR_W = $clog2(DEPTH) + 1;

    // Handshake: the CPU raises req with op/writedata and holds them until it
    // sees ready=1 at a rising edge; that edge is the accept. The block answers
    // with exactly one done pulse (err qualifies it) unless op is NOP or the
    // operation is aborted by flush/reset. ready stays low from accept to done.
    logic               req;
    stack_op_e          op;
    logic [DATA_W-1:0]  writedata;
    logic               flush;
    logic               clear_err;

    logic               ready;
    logic               done;
    logic               err;
    logic [DATA_W-1:0]  outdata;
    logic [PTR_W-1:0]   sp;
    logic               full;
    logic               empty;
    logic               overflow;
    logic               underflow;
    stack_state_e       state;

    modport master (
        output req, op, writedata, flush, clear_err,
        input  ready, done, err, outdata, sp, full, empty, overflow, underflow, state
    );

    modport slave (
        input  req, op, writedata, flush, clear_err,
        output ready, done, err, outdata, sp, full, empty, overflow, underflow, state
    );

endinterface

// File: rtl/chip8_stack_mem.sv
// Single-port synchronous stack RAM with a registered read port (one-cycle
// read latency). Contents are not reset.
module chip8_stack_mem #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            q <= mem[addr];
        end
    end

endmodule

// File: rtl/chip8_call_stack.sv
// Parametrised return-address stack for the Chip8 CPU: push/pop/peek with a
// req/done handshake, flush, full/empty status and sticky error flags.
module chip8_call_stack
    import chip8_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    localparam int PTR_W = $clog2(DEPTH) + 1,
    localparam int AW    = PTR_W - 1
) (
    input  logic              cpu_clk,
    input  logic              cpu_reset_n,
    chip8_call_stack_if.slave bus
);

    stack_state_e      state;
    logic [PTR_W-1:0]  sp_q;
    logic [DATA_W-1:0] outdata_q;
    logic [DATA_W-1:0] ram_q;
    logic              done_q;
    logic              err_q;
    logic              overflow_q;
    logic              underflow_q;

    logic              is_full;
    logic              is_empty;
    logic              accept;
    logic              do_push;
    logic              do_read;
    logic              rej_push;
    logic              rej_read;
    logic [AW-1:0]     ram_addr;

    assign is_full  = (sp_q == PTR_W'(DEPTH));
    assign is_empty = (sp_q == '0);

    // Flush outranks a request, so an accept never coincides with a flush.
    assign accept   = (state == ST_IDLE) && bus.req && !bus.flush && (bus.op != OP_NOP);
    assign do_push  = accept && (bus.op == OP_PUSH) && !is_full;
    assign rej_push = accept && (bus.op == OP_PUSH) && is_full;
    assign do_read  = accept && is_read_op(bus.op) && !is_empty;
    assign rej_read = accept && is_read_op(bus.op) && is_empty;

    // Push writes slot sp; pop/peek read slot sp-1 (modulo AW covers sp==DEPTH).
    always_comb begin
        ram_addr = sp_q[AW-1:0];
        if (!do_push) begin
            ram_addr = sp_q[AW-1:0] - 1'b1;
        end
    end

    chip8_stack_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (cpu_clk),
        .we    (do_push),
        .re    (do_read),
        .addr  (ram_addr),
        .wdata (bus.writedata),
        .q     (ram_q)
    );

    always_ff @(posedge cpu_clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            state     <= ST_IDLE;
            sp_q      <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            outdata_q <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (bus.flush) begin
                state <= ST_IDLE;
                sp_q  <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (do_push) begin
                            sp_q   <= sp_q + 1'b1;
                            done_q <= 1'b1;
                            state  <= ST_DONE;
                        end else if (rej_push || rej_read) begin
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                            state  <= ST_DONE;
                        end else if (do_read) begin
                            if (bus.op == OP_POP) begin
                                sp_q <= sp_q - 1'b1;
                            end
                            state <= ST_RD_WAIT;
                        end
                    end
                    ST_RD_WAIT: begin
                        outdata_q <= ram_q;
                        done_q    <= 1'b1;
                        state     <= ST_DONE;
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Sticky error flags: a new error in the same cycle beats clear_err.
    always_ff @(posedge cpu_clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (rej_push) begin
                overflow_q <= 1'b1;
            end else if (bus.clear_err) begin
                overflow_q <= 1'b0;
            end
            if (rej_read) begin
                underflow_q <= 1'b1;
            end else if (bus.clear_err) begin
                underflow_q <= 1'b0;
            end
        end
    end

    assign bus.ready     = (state == ST_IDLE);
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.outdata   = outdata_q;
    assign bus.sp        = sp_q;
    assign bus.full      = is_full;
    assign bus.empty     = is_empty;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
    assign bus.state     = state;

endmodule
